wait_time_display: RTL and testbench
====================================

Name: wait_time_display

Overview:
- Sequential successor to the bank queue's waiting-time decoder.
- Converts an unsigned binary waiting time of parametrised width to DIGITS decimal digits using iterative shift-add-3 (double-dabble), one bit per clock.
- Drives one 7-segment pattern per digit, with optional leading-zero blanking and overflow dashes.
- Sits between the SBqM wait-time calculator and the board's seven-segment displays; the displayed value is held stable while a new value is converted.

Parameters:
- IN_W, 5, width of the binary input value (≥1).
- DIGITS, 2, number of decimal digits and 7-segment outputs (1..6).
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board default); 0 = active-high.
- BLANK_LZ, 1, 1 = blank leading zero digits (units digit never blanked); 0 = show all zeros.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  request to convert `value`; sampled only in IDLE.
- value  in  IN_W  unsigned binary waiting time.
- busy  out  1  conversion in progress; load ignored while high.
- valid  out  1  one-cycle pulse when `seg` and `overflow` have just updated.
- overflow  out  1  last converted value exceeded 10^DIGITS-1; held until next update.
- seg  out  7*DIGITS  segment patterns; digit i (i=0 units) at seg[7i+6:7i], bit order a(MSB)..g(LSB).

Behaviour:
- Reset (async assert, sync-clean deassert) → state IDLE, busy=0, valid=0, overflow=0; seg shows "0" on units and blank on other digits (BLANK_LZ=1) or all "0" (BLANK_LZ=0). Reset mid-conversion aborts it; no valid pulse occurs.
- Segment codes (active-high form, a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - blank=0000000, dash=0000001.
  - Output is the bitwise inversion of these when SEG_ACTIVE_LOW=1.
- FSM states IDLE, SHIFT, DONE.
  - IDLE:
    - On an edge with load=1: capture value into the shift register, clear the BCD register to 0, set the bit counter to IN_W, register the overflow flag (value > 10^DIGITS-1, evaluated with constants wide enough not to truncate), and go to SHIFT.
    - busy=1 from this edge.
  - SHIFT:
    - Each cycle, every BCD nibble ≥5 gets +3, then {bcd,bin} shifts left by 1 and the counter decrements.
    - After exactly IN_W SHIFT cycles, go to DONE.
  - DONE:
    - At the next edge, update seg and overflow, pulse valid=1 for one cycle, set busy=0, and go to IDLE.
- Latency:
  - load accepted at edge 0; valid high in the cycle following edge IN_W+1.
  - Latency is fixed at IN_W+2 edges, including overflow cases.
  - The earliest next accept is edge IN_W+2.
- load while busy (SHIFT or DONE): ignored, not queued; the upstream block re-asserts it. load held high continuously restarts a conversion at each IDLE.
- seg and overflow change only on the DONE edge or on reset; no intermediate values are visible.
- Overflow=1: all DIGITS show dash, regardless of BLANK_LZ.
- Blanking (BLANK_LZ=1): digit i>0 is blanked iff it and all higher digits are 0.
- BCD register width is 4*DIGITS; carries out of the top nibble are discarded (that case is covered by overflow).
- If IN_W is too small to exceed 10^DIGITS-1, overflow is constant 0.
- value may change freely except on the accept edge.

Decomposition:
- Package sbqm_disp_pkg holds:
  - segment code constants (digits 0-9, blank, dash, active-high form);
  - FSM state encoding;
  - a constant function pow10(n) for the overflow threshold.
- Sub-module seg7_digit: combinational 4-bit BCD + blank + dash + polarity → 7 bits; instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then IN_W=5, DIGITS=2, active-low: with no load, seg[6:0]=~1111110 and seg[13:7]=~0000000, busy=0, valid=0.
- load value=31 → valid exactly 7 edges after accept (IN_W+2), units=~0110000, tens=~1111001, overflow=0, busy high for the 6 intervening cycles.
- Sweep value 0..31 each followed by a valid wait → the decimal digits read back from seg match value for all 32 codes; tens digit blank for 0..9.
- IN_W=10, DIGITS=3: value=1000 → all three digits ~0000001, overflow=1. Then value=999 → "999", overflow=0. Then value=7 → two blanks plus "7".
- load pulse mid-conversion (value=12 accepted, value=25 presented at busy) → only 12 displayed, exactly one valid pulse; the following load in IDLE converts normally.
- rst asserted on the third SHIFT cycle of value=29 → seg returns immediately to the reset pattern, busy=0, no valid pulse; after release, a conversion of 29 completes correctly.

Source files
------------

// File: rtl/wait_time_display_pkg.sv
// Shared constants for the wait-time display: segment codes (active-high, a..g),
// FSM state encoding and the decimal overflow threshold helper.
package sbqm_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/wait_time_display_if.sv
// Load/result bundle between the wait-time calculator and the display converter.
interface wait_time_display_if #(
    parameter int IN_W   = 5,
    parameter int DIGITS = 2
);
    logic                  load;
    logic [IN_W-1:0]       value;
    logic                  busy;
    logic                  valid;
    logic                  overflow;
    logic [7*DIGITS-1:0]   seg;

    modport master (output load, value, input busy, valid, overflow, seg);
    modport slave  (input load, value, output busy, valid, overflow, seg);
endinterface

// File: rtl/wait_time_display_seg7_digit.sv
// One BCD digit to 7-segment pattern; dash overrides blank, which overrides the digit.
module seg7_digit
    import sbqm_disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    logic [6:0] code;

    always_comb begin
        code = SEG_BLANK;
        if (dash) begin
            code = SEG_DASH;
        end else if (!blank) begin
            case (bcd)
                4'd0:    code = SEG_0;
                4'd1:    code = SEG_1;
                4'd2:    code = SEG_2;
                4'd3:    code = SEG_3;
                4'd4:    code = SEG_4;
                4'd5:    code = SEG_5;
                4'd6:    code = SEG_6;
                4'd7:    code = SEG_7;
                4'd8:    code = SEG_8;
                4'd9:    code = SEG_9;
                default: code = SEG_BLANK;
            endcase
        end
    end

    assign seg = ACTIVE_LOW ? ~code : code;

endmodule

// File: rtl/wait_time_display.sv
// Sequential binary-to-decimal converter (double-dabble, one bit per clock) driving
// DIGITS seven-segment outputs; the shown value only changes when a conversion completes.
module wait_time_display
    import sbqm_disp_pkg::*;
#(
    parameter int IN_W           = 5,
    parameter int DIGITS         = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    wait_time_display_if.slave bus
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    // Compare in a width that holds both the input and 10^6-1 without truncation.
    localparam int CW    = (IN_W > 24) ? IN_W : 24;
    localparam logic [CW-1:0] LIMIT = CW'(pow10(DIGITS) - 1);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  bin_q, bin_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [BW-1:0]    disp_bcd_q, disp_bcd_d;
    logic             disp_ovf_q, disp_ovf_d;
    logic             valid_q, valid_d;

    logic [BW-1:0]       adj;
    logic [DIGITS-1:0]   blank;
    logic                hi_nz;
    logic [7*DIGITS-1:0] seg_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_bcd_q <= '0;
            disp_ovf_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_bcd_q <= disp_bcd_d;
            disp_ovf_q <= disp_ovf_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_bcd_d = disp_bcd_q;
        disp_ovf_d = disp_ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    bin_d      = bus.value;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(IN_W);
                    ovf_pend_d = CW'(bus.value) > LIMIT;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                disp_bcd_d = bcd_q;
                disp_ovf_d = ovf_pend_q;
                valid_d    = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Walk from the top digit down; a digit blanks while everything above it is zero.
    always_comb begin
        hi_nz = 1'b0;
        blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_nz    = hi_nz | (disp_bcd_q[4*i +: 4] != 4'd0);
            blank[i] = BLANK_LZ && !hi_nz;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg7_digit #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dig (
            .bcd   (disp_bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .dash  (disp_ovf_q),
            .seg   (seg_w[7*g +: 7])
        );
    end

    assign bus.seg      = seg_w;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.valid    = valid_q;
    assign bus.overflow = disp_ovf_q;

endmodule

// File: tb/tb_wait_time_display.sv
// Bench for wait_time_display: a 5-bit/2-digit and a 10-bit/3-digit instance, both active-low.
module tb_wait_time_display;

    typedef struct {
        int unsigned  value;
        logic [20:0]  seg;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [20:0] seg;
        logic        ovf;
    } exp_t;

    localparam int BL = 10;
    localparam int DS = 11;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   a_vcnt;
    bit   sel;
    exp_t sbq[$];
    vec_t tv[8];

    wait_time_display_if #(.IN_W(5),  .DIGITS(2)) a_if ();
    wait_time_display_if #(.IN_W(10), .DIGITS(3)) b_if ();

    wait_time_display #(.IN_W(5), .DIGITS(2), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u_a (
        .clk (clk), .rst (rst), .bus (a_if.slave)
    );
    wait_time_display #(.IN_W(10), .DIGITS(3), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u_b (
        .clk (clk), .rst (rst), .bus (b_if.slave)
    );

    logic        s_busy, s_valid, s_ovf;
    logic [20:0] s_seg;
    assign s_busy  = sel ? b_if.busy     : a_if.busy;
    assign s_valid = sel ? b_if.valid    : a_if.valid;
    assign s_ovf   = sel ? b_if.overflow : a_if.overflow;
    assign s_seg   = sel ? b_if.seg      : {7'd0, a_if.seg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (a_if.valid) a_vcnt <= a_vcnt + 1;

    function automatic logic [6:0] c7(input int d);
        logic [6:0] h;
        case (d)
            0: h = 7'h7E;  1: h = 7'h30;  2: h = 7'h6D;  3: h = 7'h79;
            4: h = 7'h33;  5: h = 7'h5B;  6: h = 7'h5F;  7: h = 7'h70;
            8: h = 7'h7F;  9: h = 7'h7B;  BL: h = 7'h00;
            default: h = 7'h01;
        endcase
        return ~h;
    endfunction

    function automatic logic [20:0] exp_a(input int v);
        return {7'd0, (v / 10 == 0) ? c7(BL) : c7(v / 10), c7(v % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Drive one load in IDLE, queue the expectation, then wait for valid and compare.
    task automatic run(input bit s, input int v, input logic [20:0] es, input logic eo,
                       input string nm);
        int          n, nbusy, lat;
        bit          seen, stable;
        logic [20:0] prev;
        exp_t        e;
        sel = s;
        lat = s ? 12 : 7;
        @(negedge clk);
        prev = s_seg;
        if (s) begin b_if.load = 1'b1; b_if.value = 10'(v); end
        else   begin a_if.load = 1'b1; a_if.value = 5'(v);  end
        sbq.push_back('{es, eo});
        @(posedge clk);
        #1;
        a_if.load  = 1'b0;
        b_if.load  = 1'b0;
        a_if.value = 5'($urandom);
        b_if.value = 10'($urandom);
        n = 0; nbusy = 0; seen = 1'b0; stable = 1'b1;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (s_valid) seen = 1'b1;
            else begin
                if (s_busy) nbusy++;
                if (s_seg !== prev) stable = 1'b0;
            end
        end
        e = sbq.pop_front();
        chk({nm, " valid_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({nm, " latency"}, 32'(n), 32'(lat));
            chk({nm, " busy_cycles"}, 32'(nbusy), 32'(lat - 1));
            chk({nm, " busy_at_valid"}, 32'(s_busy), 32'd0);
            chk({nm, " seg"}, 32'(s_seg), 32'(e.seg));
            chk({nm, " overflow"}, 32'(s_ovf), 32'(e.ovf));
            chk({nm, " seg_held"}, 32'(stable), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vstart;
        checks = 0; failures = 0; a_vcnt = 0; sel = 1'b0;
        rst = 1'b1;
        a_if.load = 1'b0; a_if.value = '0;
        b_if.load = 1'b0; b_if.value = '0;

        tv[0] = '{1000, {c7(DS), c7(DS), c7(DS)}, 1'b1};
        tv[1] = '{999,  {c7(9),  c7(9),  c7(9)},  1'b0};
        tv[2] = '{7,    {c7(BL), c7(BL), c7(7)},  1'b0};
        tv[3] = '{0,    {c7(BL), c7(BL), c7(0)},  1'b0};
        tv[4] = '{105,  {c7(1),  c7(0),  c7(5)},  1'b0};
        tv[5] = '{1023, {c7(DS), c7(DS), c7(DS)}, 1'b1};
        tv[6] = '{10,   {c7(BL), c7(1),  c7(0)},  1'b0};
        tv[7] = '{100,  {c7(1),  c7(0),  c7(0)},  1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset a_seg", 32'(a_if.seg), 32'({7'h7F, 7'h01}));
        chk("reset a_busy", 32'(a_if.busy), 32'd0);
        chk("reset a_valid", 32'(a_if.valid), 32'd0);
        chk("reset a_ovf", 32'(a_if.overflow), 32'd0);
        chk("reset b_seg", 32'(b_if.seg), 32'({7'h7F, 7'h7F, 7'h01}));

        run(1'b0, 31, {7'd0, ~7'h79, ~7'h30}, 1'b0, "v31");
        for (int v = 0; v < 32; v++) run(1'b0, v, exp_a(v), 1'b0, $sformatf("sweep%0d", v));

        // load re-asserted while busy must be dropped, not queued
        @(negedge clk);
        sel = 1'b0;
        vstart = a_vcnt;
        a_if.load = 1'b1; a_if.value = 5'd12;
        @(posedge clk);
        #1 a_if.load = 1'b0;
        @(negedge clk);
        chk("mid busy", 32'(a_if.busy), 32'd1);
        a_if.load = 1'b1; a_if.value = 5'd25;
        repeat (2) @(negedge clk);
        a_if.load = 1'b0;
        repeat (15) @(negedge clk);
        chk("mid valid_count", 32'(a_vcnt - vstart), 32'd1);
        chk("mid seg", 32'(a_if.seg), 32'(exp_a(12)));
        run(1'b0, 25, exp_a(25), 1'b0, "after_mid");

        // reset on the third shift cycle aborts the conversion
        @(negedge clk);
        vstart = a_vcnt;
        a_if.load = 1'b1; a_if.value = 5'd29;
        @(posedge clk);
        #1 a_if.load = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort seg", 32'(a_if.seg), 32'({7'h7F, 7'h01}));
        chk("abort busy", 32'(a_if.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort no_valid", 32'(a_vcnt - vstart), 32'd0);
        run(1'b0, 29, exp_a(29), 1'b0, "after_abort");

        for (int i = 0; i < 8; i++)
            run(1'b1, int'(tv[i].value), tv[i].seg, tv[i].ovf, $sformatf("tbl%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
